// File: rtl/bus_xfer_sched_pkg.sv
// Shared FSM state type and one-hot decode helper for bus_xfer_sched.
// The CLEAR state exists only when BUS_XFER_SCHED_CLR_EN is defined.
package bus_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      LATCH,
      TURN
`ifdef BUS_XFER_SCHED_CLR_EN
      , CLEAR
`endif
   } state_t;

   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 32; i++)
         if (oh[i]) idx = i;
      return idx;
   endfunction

endpackage

// File: rtl/bus_xfer_sched_if.sv
// Requester/register-control bundle for bus_xfer_sched.
// op_clr and reg_clr_n exist only when BUS_XFER_SCHED_CLR_EN is defined.
interface bus_xfer_sched_if #(
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int AW   = 3
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] src;
   logic [NREQ*AW-1:0] dst;
   logic [NREQ-1:0]    gnt;
   logic [NREG-1:0]    reg_oe_n;
   logic [NREG-1:0]    reg_en_n;
   logic               busy;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic               err;

`ifdef BUS_XFER_SCHED_CLR_EN
   logic [NREQ-1:0]    op_clr;
   logic [NREG-1:0]    reg_clr_n;

   modport slave  (input  req, src, dst, op_clr,
                   output gnt, reg_oe_n, reg_en_n, busy, done, done_id, err, reg_clr_n);
   modport master (output req, src, dst, op_clr,
                   input  gnt, reg_oe_n, reg_en_n, busy, done, done_id, err, reg_clr_n);
`else
   modport slave  (input  req, src, dst,
                   output gnt, reg_oe_n, reg_en_n, busy, done, done_id, err);
   modport master (output req, src, dst,
                   input  gnt, reg_oe_n, reg_en_n, busy, done, done_id, err);
`endif

endinterface

// File: rtl/bus_xfer_sched_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_arbiter
   import bus_xfer_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] win,
   output logic [IDW-1:0]  win_idx,
   output logic            any
);

   always_comb begin
      logic        w_found;
      int unsigned w_pos;
      win     = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_pos = (32'(ptr) + i) % NREQ;
         if (!w_found && req[w_pos]) begin
            win[w_pos] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

   assign win_idx = IDW'(onehot_to_idx(32'(win)));
   assign any     = |req;

endmodule

// File: rtl/bus_xfer_sched.sv
// Round-robin scheduler moving bytes between 74AS825-style bus registers.
// Optional register-clear operation enabled by BUS_XFER_SCHED_CLR_EN.
module bus_xfer_sched
   import bus_xfer_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int AW   = 3
)(
   input  logic          clk,
   input  logic          rst_n,
   bus_xfer_sched_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          r_state;
   logic            r_armed;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [AW-1:0]   r_src;
   logic [AW-1:0]   r_dst;
   logic [NREQ-1:0] r_gnt;
   logic [NREG-1:0] r_oe_n;
   logic [NREG-1:0] r_en_n;
   logic            r_done;
   logic            r_err;
   logic [IDW-1:0]  r_done_id;

   logic [NREQ-1:0] w_win;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
   logic            w_bad;
   logic            w_dst_oor;

`ifdef BUS_XFER_SCHED_CLR_EN
   logic            r_clr;
   logic [NREG-1:0] r_clr_n;
`endif

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (bus.req),
      .ptr     (r_ptr),
      .win     (w_win),
      .win_idx (w_idx),
      .any     (w_any)
   );

   assign w_dst_oor = (32'(r_dst) >= NREG);
   assign w_bad     = (r_src == r_dst) || (32'(r_src) >= NREG) || w_dst_oor;

   // Outputs trail the state by one cycle: DRIVE/LATCH program OE/EN for the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_armed   <= 1'b0;
         r_ptr     <= '0;
         r_id      <= '0;
         r_src     <= '0;
         r_dst     <= '0;
         r_gnt     <= '0;
         r_oe_n    <= '1;
         r_en_n    <= '1;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_done_id <= '0;
`ifdef BUS_XFER_SCHED_CLR_EN
         r_clr     <= 1'b0;
         r_clr_n   <= '1;
`endif
      end else begin
         r_armed <= 1'b1;
         r_gnt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_armed && w_any) begin
                  r_gnt <= w_win;
                  r_id  <= w_idx;
                  r_src <= bus.src[32'(w_idx)*AW +: AW];
                  r_dst <= bus.dst[32'(w_idx)*AW +: AW];
                  r_ptr <= IDW'((32'(w_idx) + 1) % NREQ);
`ifdef BUS_XFER_SCHED_CLR_EN
                  r_clr   <= bus.op_clr[w_idx];
                  r_state <= bus.op_clr[w_idx] ? CLEAR : DRIVE;
`else
                  r_state <= DRIVE;
`endif
               end
            end
            DRIVE: begin
               if (w_bad) begin
                  r_state <= TURN;
               end else begin
                  r_oe_n[r_src] <= 1'b0;
                  r_state       <= LATCH;
               end
            end
            LATCH: begin
               r_en_n[r_dst] <= 1'b0;
               r_state       <= TURN;
            end
`ifdef BUS_XFER_SCHED_CLR_EN
            CLEAR: begin
               if (!w_dst_oor) r_clr_n[r_dst] <= 1'b0;
               r_state <= TURN;
            end
`endif
            TURN: begin
               r_oe_n    <= '1;
               r_en_n    <= '1;
               r_done    <= 1'b1;
               r_done_id <= r_id;
`ifdef BUS_XFER_SCHED_CLR_EN
               r_clr_n   <= '1;
               r_err     <= r_clr ? w_dst_oor : w_bad;
`else
               r_err     <= w_bad;
`endif
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.reg_oe_n = r_oe_n;
   assign bus.reg_en_n = r_en_n;
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = r_done;
   assign bus.done_id  = r_done_id;
   assign bus.err      = r_err;
`ifdef BUS_XFER_SCHED_CLR_EN
   assign bus.reg_clr_n = r_clr_n;
`endif

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Self-checking bench for bus_xfer_sched: scenario tasks plus a completion scoreboard.
module tb_bus_xfer_sched;
   import bus_xfer_pkg::*;

   localparam int NREQ = 4;
   localparam int NREG = 8;
   localparam int AW   = 3;

   typedef struct packed {
      logic [1:0] id;
      logic       err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   bus_xfer_sched_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) bus ();

   bus_xfer_sched #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Continuous invariants and scoreboard retirement on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         n_checks++;
         if (!$onehot0(~bus.reg_oe_n) || !$onehot0(~bus.reg_en_n) ||
             (bus.busy !== (dut.r_state != IDLE)))
            $display("FAIL invariant t=%0t oe_n=%b en_n=%b busy=%b state=%0d required onehot0 OE/EN and busy==(state!=IDLE)",
                     $time, bus.reg_oe_n, bus.reg_en_n, bus.busy, dut.r_state);
         else
            n_pass++;
         if (bus.done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected_done t=%0t done_id=%0d err=%b required no done", $time, bus.done_id, bus.err);
            end else begin
               e = sb.pop_front();
               if (bus.done_id !== e.id || bus.err !== e.err)
                  $display("FAIL sb_done t=%0t done_id=%0d err=%b required done_id=%0d err=%b",
                           $time, bus.done_id, bus.err, e.id, e.err);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic set_sd(input int i, input int s, input int d);
      bus.src[i*AW +: AW] = AW'(s);
      bus.dst[i*AW +: AW] = AW'(d);
   endtask

   task automatic drain(input string name);
      int unsigned k;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      else
         n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req = '0;
      bus.src = '0;
      bus.dst = '0;
`ifdef BUS_XFER_SCHED_CLR_EN
      bus.op_clr = '0;
`endif
      #2 rst_n = 1'b0;
      set_sd(0, 2, 5);
      bus.req = 4'b0001;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.busy, bus.done, bus.err, bus.done_id} !==
          {4'b0000, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_values gnt=%b oe_n=%h en_n=%h busy=%b done=%b err=%b id=%0d required 0000/FF/FF/0/0/0/0",
                  bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.busy, bus.done, bus.err, bus.done_id);
      else
         n_pass++;
      sb.push_back(exp_t'{id: 2'd0, err: 1'b0});
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000)
         $display("FAIL reset_first_edge gnt=%b required 0000", bus.gnt);
      else
         n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0001)
         $display("FAIL reset_second_edge gnt=%b required 0001", bus.gnt);
      else
         n_pass++;
      bus.req = '0;
      drain("reset");
   endtask

   task automatic test_single();
      logic [3:0] e_gnt [4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic [7:0] e_oe  [4]  = '{8'hFF, 8'hFB, 8'hFB, 8'hFF};
      logic [7:0] e_en  [4]  = '{8'hFF, 8'hFF, 8'hDF, 8'hFF};
      logic       e_done[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       e_busy[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      set_sd(0, 2, 5);
      bus.req = 4'b0001;
      sb.push_back(exp_t'{id: 2'd0, err: 1'b0});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.busy} !==
             {e_gnt[c], e_oe[c], e_en[c], e_done[c], e_busy[c]})
            $display("FAIL single_c%0d gnt=%b oe_n=%h en_n=%h done=%b busy=%b required %b/%h/%h/%b/%b",
                     c + 1, bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.busy,
                     e_gnt[c], e_oe[c], e_en[c], e_done[c], e_busy[c]);
         else
            n_pass++;
         if (c == 0) bus.req = '0;
      end
      drain("single");
   endtask

   task automatic test_back_to_back();
      int         gcyc[5];
      logic [3:0] gval[5];
      int         k;
      int         order[5] = '{0, 1, 2, 3, 0};
      k = 0;
      rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_sd(i, i, 7 - i);
      for (int i = 0; i < 5; i++) sb.push_back(exp_t'{id: 2'(order[i]), err: 1'b0});
      bus.req = 4'b1111;
      rst_n = 1'b1;
      for (int c = 1; c <= 40 && k < 5; c++) begin
         @(negedge clk);
         if (bus.gnt !== 4'b0000) begin
            gcyc[k] = c;
            gval[k] = bus.gnt;
            k++;
            if (k == 5) bus.req = '0;
         end
      end
      bus.req = '0;
      n_checks++;
      if (k != 5)
         $display("FAIL b2b_grant_count got=%0d required 5", k);
      else
         n_pass++;
      for (int j = 0; j < k; j++) begin
         n_checks++;
         if (gval[j] !== 4'(1 << order[j]))
            $display("FAIL b2b_order_%0d gnt=%b required %b", j, gval[j], 4'(1 << order[j]));
         else
            n_pass++;
         if (j > 0) begin
            n_checks++;
            if (gcyc[j] - gcyc[j-1] != 4)
               $display("FAIL b2b_spacing_%0d gap=%0d required 4", j, gcyc[j] - gcyc[j-1]);
            else
               n_pass++;
         end
      end
      drain("b2b");
   endtask

   task automatic test_error();
      logic [3:0] e_gnt [3] = '{4'b0010, 4'b0000, 4'b0000};
      logic       e_done[3] = '{1'b0, 1'b0, 1'b1};
      logic       e_err [3] = '{1'b0, 1'b0, 1'b1};
      logic       e_busy[3] = '{1'b1, 1'b1, 1'b0};
      set_sd(1, 4, 4);
      bus.req = 4'b0010;
      sb.push_back(exp_t'{id: 2'd1, err: 1'b1});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.err, bus.busy} !==
             {e_gnt[c], 8'hFF, 8'hFF, e_done[c], e_err[c], e_busy[c]})
            $display("FAIL error_c%0d gnt=%b oe_n=%h en_n=%h done=%b err=%b busy=%b required %b/FF/FF/%b/%b/%b",
                     c + 1, bus.gnt, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.err, bus.busy,
                     e_gnt[c], e_done[c], e_err[c], e_busy[c]);
         else
            n_pass++;
         if (c == 0) bus.req = '0;
      end
      drain("error");
   endtask

   task automatic test_mid_reset();
      int dones;
      dones = 0;
      set_sd(2, 1, 3);
      bus.req = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0100)
         $display("FAIL midrst_grant gnt=%b required 0100", bus.gnt);
      else
         n_pass++;
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.reg_oe_n !== 8'hFD || bus.reg_en_n !== 8'hF7)
         $display("FAIL midrst_latch oe_n=%h en_n=%h required FD/F7", bus.reg_oe_n, bus.reg_en_n);
      else
         n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.reg_oe_n !== 8'hFF || bus.reg_en_n !== 8'hFF || bus.busy !== 1'b0)
         $display("FAIL midrst_release oe_n=%h en_n=%h busy=%b required FF/FF/0", bus.reg_oe_n, bus.reg_en_n, bus.busy);
      else
         n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0)
         $display("FAIL midrst_no_done dones=%0d required 0", dones);
      else
         n_pass++;
   endtask

`ifdef BUS_XFER_SCHED_CLR_EN
   task automatic test_clear();
      logic [3:0] e_gnt [3] = '{4'b0001, 4'b0000, 4'b0000};
      logic [7:0] e_clr [3] = '{8'hFF, 8'hBF, 8'hFF};
      logic       e_done[3] = '{1'b0, 1'b0, 1'b1};
      set_sd(0, 3, 6);
      bus.op_clr = 4'b0001;
      bus.req    = 4'b0001;
      sb.push_back(exp_t'{id: 2'd0, err: 1'b0});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.gnt, bus.reg_clr_n, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.err} !==
             {e_gnt[c], e_clr[c], 8'hFF, 8'hFF, e_done[c], 1'b0})
            $display("FAIL clear_c%0d gnt=%b clr_n=%h oe_n=%h en_n=%h done=%b err=%b required %b/%h/FF/FF/%b/0",
                     c + 1, bus.gnt, bus.reg_clr_n, bus.reg_oe_n, bus.reg_en_n, bus.done, bus.err,
                     e_gnt[c], e_clr[c], e_done[c]);
         else
            n_pass++;
         if (c == 0) begin
            bus.req    = '0;
            bus.op_clr = '0;
         end
      end
      drain("clear");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_error();
      test_mid_reset();
`ifdef BUS_XFER_SCHED_CLR_EN
      test_clear();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
